// File: rtl/peripheral_mpram_arbiter_wb.sv
// Round-robin Wishbone classic arbiter that shares one byte-lane RAM between
// PORTS masters, sequencing one word access at a time (IDLE -> XFER -> ACK, or ERR).
module peripheral_mpram_arbiter_wb #(
  parameter int PORTS = 2,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORTS*32-1:0] wb_adr_i,
  input  logic [PORTS*DW-1:0] wb_dat_i,
  input  logic [PORTS*4-1:0]  wb_sel_i,
  input  logic [PORTS-1:0]    wb_we_i,
  input  logic [PORTS-1:0]    wb_cyc_i,
  input  logic [PORTS-1:0]    wb_stb_i,
  output logic [PORTS*DW-1:0] wb_dat_o,
  output logic [PORTS-1:0]    wb_ack_o,
  output logic [PORTS-1:0]    wb_err_o,
  output logic [3:0]          ram_we,
  output logic [DW-1:0]       ram_din,
  output logic [AW-1:0]       ram_waddr,
  output logic [AW-1:0]       ram_raddr,
  input  logic [DW-1:0]       ram_dout
);

  localparam int            GW        = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [GW-1:0] LAST_PORT = GW'(PORTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;

  logic [PORTS-1:0] req_s;
  logic             grant_req_s;
  logic             found_s;
  logic [GW-1:0]    pick_s;
  logic [31:0]      pick_adr_s;
  int               cand_s;

  // Any byte-address bit above the RAM's word range marks the access as out of range.
  function automatic logic out_of_range(input logic [31:0] adr);
    logic oor;
    oor = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i >= AW + 2) begin
        oor = oor | adr[i];
      end else begin
        oor = oor;
      end
    end
    return oor;
  endfunction

  assign req_s       = wb_cyc_i & wb_stb_i;
  assign grant_req_s = req_s[grant_q];
  assign pick_adr_s  = wb_adr_i[int'(pick_s)*32 +: 32];

  // Round-robin search upward from last_grant+1, so the port just served ranks last.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_grant_q;
    cand_s  = 0;
    for (int k = 1; k <= PORTS; k++) begin
      cand_s = int'(last_grant_q) + k;
      if (cand_s >= PORTS) begin
        cand_s = cand_s - PORTS;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_s[GW'(cand_s)]) begin
        found_s = 1'b1;
        pick_s  = GW'(cand_s);
      end else begin
        found_s = found_s;
        pick_s  = pick_s;
      end
    end
  end

  // Next-state and output decode; strobes look at the live request so a dropped
  // cycle suppresses the write or the ack in the very cycle it disappears.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    data_d       = data_q;
    ram_we       = 4'b0000;
    wb_ack_o     = '0;
    wb_err_o     = '0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          grant_d      = pick_s;
          last_grant_d = pick_s;
          addr_d       = pick_adr_s[AW+1:2];
          we_d         = wb_we_i[pick_s];
          sel_d        = wb_sel_i[int'(pick_s)*4 +: 4];
          data_d       = wb_dat_i[int'(pick_s)*DW +: DW];
          state_d      = out_of_range(pick_adr_s) ? ERR : XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (grant_req_s) begin
          ram_we  = we_q ? sel_q : 4'b0000;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (grant_req_s) begin
          wb_ack_o[grant_q] = 1'b1;
        end else begin
          wb_ack_o = '0;
        end
        state_d = IDLE;
      end
      ERR: begin
        if (grant_req_s) begin
          wb_err_o[grant_q] = 1'b1;
        end else begin
          wb_err_o = '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, arbitration history and transaction latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_PORT;
      grant_q      <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      sel_q        <= 4'b0000;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
    end
  end

  // Both RAM addresses follow the latch so ram_dout stays stable into ACK.
  assign ram_waddr = addr_q;
  assign ram_raddr = addr_q;
  assign ram_din   = data_q;
  assign wb_dat_o  = {PORTS{ram_dout}};

endmodule
